// File: rtl/fetch_unit_pkg.sv
// Shared front-end definitions: data widths, fetch defaults, FSM and
// next-PC select encodings, the pending-redirect payload and the RV32I
// major opcodes used across the pipeline.
package fetch_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IMEM_AW = 14;

    // Default first fetch address and bubble instruction (addi x0,x0,0)
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h4000_0000;
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    // Fetch front-end states
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

    // Which priority level won the next-PC selection this cycle
    typedef enum logic [1:0] {
        SEL_FREEZE   = 2'd0,
        SEL_REDIRECT = 2'd1,
        SEL_REPLAY   = 2'd2,
        SEL_SEQ      = 2'd3
    } pc_sel_e;

    // Redirect captured while the front end is stalled
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] target;
    } redirect_t;

    // Word address into the 64 KiB instruction memory
    function automatic logic [IMEM_AW-1:0] word_addr(input logic [XLEN-1:0] pc);
        return pc[IMEM_AW+1:2];
    endfunction

    // Force a byte address onto a word boundary
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// pc_next_sel: combinational next-PC mux for the fetch front end.
// Priority: stall > redirect (live or pending) > load-use replay > sequential.
// Ports:
//   stall, redirect_take, redirect_target, hold_req : selection inputs
//   fetch_pc, pc_out                                 : current PC registers
//   sel_c, next_fetch_pc_c, next_pc_out_c            : chosen path and next PCs
module pc_next_sel
    import fetch_unit_pkg::*;
(
    input  logic            stall,
    input  logic            redirect_take,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            hold_req,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [XLEN-1:0] pc_out,
    output pc_sel_e         sel_c,
    output logic [XLEN-1:0] next_fetch_pc_c,
    output logic [XLEN-1:0] next_pc_out_c
);

    // Sequential advance is the default; higher priorities override it
    always_comb begin
        sel_c           = SEL_SEQ;
        next_fetch_pc_c = fetch_pc + XLEN'(4);
        next_pc_out_c   = fetch_pc;
        if (stall) begin
            sel_c           = SEL_FREEZE;
            next_fetch_pc_c = fetch_pc;
            next_pc_out_c   = pc_out;
        end else if (redirect_take) begin
            // Target is fetched next cycle and reported as pc_out during the squash
            sel_c           = SEL_REDIRECT;
            next_fetch_pc_c = redirect_target;
            next_pc_out_c   = redirect_target;
        end else if (hold_req) begin
            sel_c           = SEL_REPLAY;
            next_fetch_pc_c = fetch_pc;
            next_pc_out_c   = pc_out;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with stall, load-use hold and
// branch/jump redirect handling against a one-cycle-latency instruction memory.
// Ports:
//   clk, rst (sync, active-high)
//   stall, load_hazard, redirect_valid, redirect_pc : pipeline control
//   imem_addr, imem_rdata                           : instruction memory
//   inst_out, pc_out, pc_tag, inst_valid            : to decode / hazard unit
// fetch_pc is the address being issued; pc_out is the address whose data
// returns this cycle. inst_out/inst_valid decode the registered state and
// pass memory read data straight through while running.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               load_hazard,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    inst_out,
    output logic [XLEN-1:0]    pc_out,
    output logic [IMEM_AW-1:0] pc_tag,
    output logic               inst_valid
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] pc_out_q;
    logic [XLEN-1:0] hold_inst_q;
    redirect_t       pend_q;

    logic            redirect_take_c;
    logic [XLEN-1:0] redirect_target_c;
    logic            hold_req_c;
    logic            hold_capture_c;
    pc_sel_e         sel_c;
    logic [XLEN-1:0] next_fetch_pc_c;
    logic [XLEN-1:0] next_pc_out_c;

    // A live redirect is newer than any pending one; load hazards only
    // matter while a real instruction is being presented
    always_comb begin
        redirect_take_c   = redirect_valid | pend_q.valid;
        redirect_target_c = redirect_valid ? align_word(redirect_pc) : pend_q.target;
        hold_req_c        = load_hazard && ((state_q == ST_RUN) || (state_q == ST_HOLD));
    end

    pc_next_sel u_pc_next_sel (
        .stall           (stall),
        .redirect_take   (redirect_take_c),
        .redirect_target (redirect_target_c),
        .hold_req        (hold_req_c),
        .fetch_pc        (fetch_pc_q),
        .pc_out          (pc_out_q),
        .sel_c           (sel_c),
        .next_fetch_pc_c (next_fetch_pc_c),
        .next_pc_out_c   (next_pc_out_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and instruction presentation
    always_comb begin
        state_d        = state_q;
        inst_out       = NOP_INST;
        inst_valid     = 1'b0;
        hold_capture_c = 1'b0;

        case (state_q)
            ST_RUN: begin
                inst_out   = imem_rdata;
                inst_valid = 1'b1;
            end
            ST_HOLD: begin
                inst_out   = hold_inst_q;
                inst_valid = 1'b1;
            end
            default: begin
            end
        endcase

        case (sel_c)
            SEL_REDIRECT: state_d = ST_FLUSH;
            SEL_SEQ:      state_d = ST_RUN;
            SEL_FREEZE, SEL_REPLAY: begin
                // Freezing in BOOT/FLUSH/HOLD keeps the state; RUN parks its data
                if (state_q == ST_RUN) begin
                    state_d        = ST_HOLD;
                    hold_capture_c = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // PC, held-instruction and pending-redirect registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            pc_out_q    <= RESET_PC;
            hold_inst_q <= NOP_INST;
            pend_q      <= '0;
        end else begin
            fetch_pc_q <= next_fetch_pc_c;
            pc_out_q   <= next_pc_out_c;

            if (hold_capture_c) begin
                hold_inst_q <= imem_rdata;
            end else if (sel_c == SEL_REDIRECT) begin
                hold_inst_q <= NOP_INST;
            end

            // Latest redirect seen during a stall wins; consumed once stall drops
            if (stall) begin
                if (redirect_valid) begin
                    pend_q <= '{valid: 1'b1, target: align_word(redirect_pc)};
                end
            end else begin
                pend_q <= '0;
            end
        end
    end

    // Reset forces the boot address onto the memory port immediately
    always_comb begin
        imem_addr = rst ? word_addr(RESET_PC) : word_addr(fetch_pc_q);
        pc_out    = pc_out_q;
        pc_tag    = word_addr(pc_out_q);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instruction memory
// whose word at address a is {16'hC0DE, 2'b00, a}.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        load_hazard;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [13:0] pc_tag;
    logic        inst_valid;

    int tests = 0;
    int fails = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .load_hazard    (load_hazard),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .pc_tag         (pc_tag),
        .inst_valid     (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a};
    endfunction

    function automatic logic [31:0] mi(input logic [31:0] pc);
        return mem_word(pc[15:2]);
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                       input logic v);
        logic [13:0] t;
        t = pc[15:2];
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".inst"}, inst_out, inst);
        chk({tag, ".valid"}, 32'(inst_valid), 32'(v));
        chk({tag, ".tag"}, 32'(pc_tag), 32'(t));
    endtask

    initial begin
        logic [13:0] ra;
        ra             = RST_PC[15:2];
        rst            = 1'b1;
        stall          = 1'b0;
        load_hazard    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset and boot
        tick(); tick();
        chk("rst_addr", 32'(imem_addr), 32'(ra));
        cyc("rst", RST_PC, NOP, 1'b0);
        rst = 1'b0;
        #1;
        cyc("boot", RST_PC, NOP, 1'b0);
        chk("boot_addr", 32'(imem_addr), 32'(ra));

        // Free run
        tick(); cyc("run0", 32'h4000_0000, mi(32'h4000_0000), 1'b1);
        chk("run0_addr", 32'(imem_addr), 32'd1);
        tick(); cyc("run1", 32'h4000_0004, mi(32'h4000_0004), 1'b1);
        tick(); cyc("run2", 32'h4000_0008, mi(32'h4000_0008), 1'b1);

        // One-cycle load-use hold
        load_hazard = 1'b1;
        tick(); cyc("lh_hold", 32'h4000_0008, mi(32'h4000_0008), 1'b1);
        chk("lh_addr", 32'(imem_addr), 32'd3);
        load_hazard = 1'b0;
        tick(); cyc("lh_resume", 32'h4000_000C, mi(32'h4000_000C), 1'b1);

        // Redirect with misaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0103;
        tick(); cyc("rd_flush", 32'h4000_0100, NOP, 1'b0);
        chk("rd_addr", 32'(imem_addr), 32'h40);
        redirect_valid = 1'b0;
        tick(); cyc("rd_run", 32'h4000_0100, mi(32'h4000_0100), 1'b1);
        tick(); cyc("rd_run1", 32'h4000_0104, mi(32'h4000_0104), 1'b1);
        tick(); cyc("st_a", 32'h4000_0108, mi(32'h4000_0108), 1'b1);

        // Three-cycle stall with a redirect in its second cycle
        stall = 1'b1;
        tick(); cyc("st_b", 32'h4000_0108, mi(32'h4000_0108), 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0200;
        tick(); cyc("st_c", 32'h4000_0108, mi(32'h4000_0108), 1'b1);
        redirect_valid = 1'b0;
        tick(); cyc("st_d", 32'h4000_0108, mi(32'h4000_0108), 1'b1);
        stall = 1'b0;
        tick(); cyc("st_flush", 32'h4000_0200, NOP, 1'b0);
        load_hazard = 1'b1;  // ignored in FLUSH
        tick(); cyc("st_run", 32'h4000_0200, mi(32'h4000_0200), 1'b1);
        load_hazard = 1'b0;
        tick(); cyc("st_run1", 32'h4000_0204, mi(32'h4000_0204), 1'b1);

        // Later redirect during a stall overwrites the pending one
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0400;
        tick(); cyc("pend_a", 32'h4000_0204, mi(32'h4000_0204), 1'b1);
        redirect_pc = 32'h4000_0500;
        tick(); cyc("pend_b", 32'h4000_0204, mi(32'h4000_0204), 1'b1);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        tick(); cyc("pend_flush", 32'h4000_0500, NOP, 1'b0);
        tick(); cyc("pend_run", 32'h4000_0500, mi(32'h4000_0500), 1'b1);

        // Wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick(); cyc("wr_flush", 32'hFFFF_FFFC, NOP, 1'b0);
        chk("wr_addr", 32'(imem_addr), 32'h3FFF);
        redirect_valid = 1'b0;
        tick(); cyc("wr_top", 32'hFFFF_FFFC, mi(32'hFFFF_FFFC), 1'b1);
        tick(); cyc("wr_zero", 32'h0000_0000, mi(32'h0000_0000), 1'b1);
        chk("wr_addr1", 32'(imem_addr), 32'd1);

        // Redirect beats an ongoing hold
        load_hazard = 1'b1;
        tick(); cyc("hr_hold", 32'h0000_0000, mi(32'h0000_0000), 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0600;
        tick(); cyc("hr_flush", 32'h4000_0600, NOP, 1'b0);
        redirect_valid = 1'b0;
        load_hazard    = 1'b0;
        tick(); cyc("hr_run", 32'h4000_0600, mi(32'h4000_0600), 1'b1);

        // Reset in the middle of a hold
        load_hazard = 1'b1;
        tick(); cyc("rh_hold", 32'h4000_0600, mi(32'h4000_0600), 1'b1);
        rst = 1'b1;
        tick(); cyc("rh_boot", RST_PC, NOP, 1'b0);
        chk("rh_addr", 32'(imem_addr), 32'(ra));
        rst         = 1'b0;
        load_hazard = 1'b0;
        tick(); cyc("rh_run", RST_PC, mi(RST_PC), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), the bubble instruction.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall  input  1  global memory/IO stall; freezes the whole front end.
REQ-006 SHALL have port load_hazard  input  1  load-use hazard from the hazard controller; holds the current instruction one more cycle.
REQ-007 SHALL have port redirect_valid  input  1  taken branch, JAL or JALR resolved in X.
REQ-008 SHALL have port redirect_pc  input  32  target address for a redirect.
REQ-009 SHALL have port imem_addr  output  14  word address to instruction memory, equal to fetch_pc[15:2].
REQ-010 SHALL have port imem_rdata  input  32  instruction memory data, valid one cycle after imem_addr.
REQ-011 SHALL have port inst_out  output  32  instruction presented to decode/X.
REQ-012 SHALL have port pc_out  output  32  PC of inst_out.
REQ-013 SHALL have port pc_tag  output  14  pc_out[15:2], used by the hazard controller for PC compare.
REQ-014 SHALL have port inst_valid  output  1  inst_out is a real, non-squashed instruction.

Function
REQ-015 SHALL keep fetch_pc (address being issued) and pc_out (address whose data returns this cycle), so pc_out equals the previous cycle's fetch_pc when advancing.
REQ-016 SHALL implement an FSM with states BOOT, RUN, HOLD, FLUSH.
REQ-017 BOOT: first cycle after rst deasserts; imem_addr = RESET_PC[15:2]; inst_out = NOP_INST, inst_valid = 0; then goes to RUN.
REQ-018 RUN: inst_out = imem_rdata, inst_valid = 1; fetch_pc advances by 4 each cycle, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
REQ-019 Priority each cycle: rst > stall > redirect_valid > load_hazard > sequential advance.
REQ-020 stall or load_hazard in RUN: captures imem_rdata into hold_inst, freezes fetch_pc and pc_out, goes to HOLD; inst_out keeps the held value with inst_valid = 1.
REQ-021 HOLD: outputs hold_inst; imem_addr re-presents the address after pc_out; returns to RUN (sequential advance) in the first cycle in which stall and load_hazard are both 0.
REQ-022 redirect_valid with stall = 0: next fetch_pc = {redirect_pc[31:2], 2'b00} (low bits forced to zero); goes to FLUSH.
REQ-023 FLUSH: one cycle; inst_out = NOP_INST, inst_valid = 0 (wrong-path squash); pc_out = redirect target; then RUN.
REQ-024 redirect_valid with stall = 1: latches target into pending_redirect; applies it in the first cycle with stall = 0, as REQ-022; a later redirect before then overwrites the pending target.
REQ-025 load_hazard in FLUSH or BOOT: ignored (no real instruction to hold).
REQ-026 redirect_valid in HOLD with stall = 0: redirect wins; hold_inst is discarded.

Reset
REQ-027 rst asserted at any cycle, including mid-HOLD or mid-FLUSH, SHALL on the next edge set state = BOOT, fetch_pc = RESET_PC, pc_out = RESET_PC, hold_inst = NOP_INST, pending_redirect cleared, inst_out = NOP_INST, inst_valid = 0.
REQ-028 While rst is high, imem_addr SHALL equal RESET_PC[15:2].

Structure
REQ-029 FSM state encoding, RESET_PC and NOP_INST defaults SHALL live in a shared header with the existing opcode definitions.
REQ-030 A sub-module pc_next_sel (combinational next-PC mux implementing the REQ-019 priority) SHALL be used; all other logic stays in fetch_unit.

Verification
REQ-031 Reset, then 4 free-run cycles -> pc_out 4000_0000, _0004, _0008, _000C; inst_valid 0 in BOOT only.
REQ-032 load_hazard for 1 cycle at pc_out 4000_0008 -> same inst_out and pc_out for 2 cycles, then 4000_000C.
REQ-033 redirect_valid, redirect_pc = 4000_0103 -> next cycle inst_out 0000_0013, inst_valid 0; then pc_out 4000_0100, inst_valid 1.
REQ-034 stall held 3 cycles with redirect_valid in its 2nd cycle (target 4000_0200) -> outputs frozen 3 cycles, then FLUSH, then pc_out 4000_0200.
REQ-035 fetch_pc FFFF_FFFC, no hazards -> following pc_out 0000_0000.
REQ-036 rst asserted in HOLD -> next cycle state BOOT, pc_out 4000_0000, inst_valid 0.
